// File: rtl/renkon_pkg.sv
// rtl/renkon_pkg.sv - shared FSM state and descriptor-field encodings for layer_sched
// Purpose: single home for the scheduler state enum and the cfg_sel field codes,
//          so the scheduler and its descriptor table agree on field numbering.
// Ports:   none (package).
package renkon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_ACK_LO,
    S_RUN,
    S_NEXT
  } state_e;

  localparam logic [2:0] CFG_TOTAL_OUT = 3'd0;
  localparam logic [2:0] CFG_TOTAL_IN  = 3'd1;
  localparam logic [2:0] CFG_IMG_SIZE  = 3'd2;
  localparam logic [2:0] CFG_FIL_SIZE  = 3'd3;
  localparam logic [2:0] CFG_NET_WORDS = 3'd4;

  // Codes above CFG_NET_WORDS address no field and are silently ignored.
  function automatic logic cfg_sel_valid(input logic [2:0] sel);
    return sel <= CFG_NET_WORDS;
  endfunction

endpackage

// File: rtl/layer_table.sv
// rtl/layer_table.sv - per-layer descriptor register file
// Purpose: MAXLAYER x 5-field table, one synchronous write port, one read port
//          whose address is registered (data valid one cycle after rd_layer).
// Ports:   clk; wr_en/wr_layer/wr_sel/wr_data write one field;
//          rd_layer read address; rd_* the five fields of the registered entry.
module layer_table
  import renkon_pkg::*;
#(
  parameter int LWIDTH   = 16,
  parameter int NETSIZE  = 14,
  parameter int MAXLAYER = 16,
  parameter int LAYERLOG = 4
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [LAYERLOG-1:0] wr_layer,
  input  logic [2:0]          wr_sel,
  input  logic [LWIDTH-1:0]   wr_data,
  input  logic [LAYERLOG-1:0] rd_layer,
  output logic [LWIDTH-1:0]   rd_total_out,
  output logic [LWIDTH-1:0]   rd_total_in,
  output logic [LWIDTH-1:0]   rd_img_size,
  output logic [LWIDTH-1:0]   rd_fil_size,
  output logic [NETSIZE-1:0]  rd_net_words
);

  logic [LWIDTH-1:0]   total_out_mem [MAXLAYER];
  logic [LWIDTH-1:0]   total_in_mem  [MAXLAYER];
  logic [LWIDTH-1:0]   img_size_mem  [MAXLAYER];
  logic [LWIDTH-1:0]   fil_size_mem  [MAXLAYER];
  logic [NETSIZE-1:0]  net_words_mem [MAXLAYER];
  logic [LAYERLOG-1:0] rd_layer_q;

  // Contents are host-owned, so nothing here is reset. Registering the
  // address (not the data) means a write on the same edge is visible to the
  // read that follows it.
  always_ff @(posedge clk) begin
    rd_layer_q <= rd_layer;
    if (wr_en) begin
      case (wr_sel)
        CFG_TOTAL_OUT: total_out_mem[wr_layer] <= wr_data;
        CFG_TOTAL_IN:  total_in_mem[wr_layer]  <= wr_data;
        CFG_IMG_SIZE:  img_size_mem[wr_layer]  <= wr_data;
        CFG_FIL_SIZE:  fil_size_mem[wr_layer]  <= wr_data;
        CFG_NET_WORDS: net_words_mem[wr_layer] <= wr_data[NETSIZE-1:0];
        default: ;
      endcase
    end
  end

  assign rd_total_out = total_out_mem[rd_layer_q];
  assign rd_total_in  = total_in_mem[rd_layer_q];
  assign rd_img_size  = img_size_mem[rd_layer_q];
  assign rd_fil_size  = fil_size_mem[rd_layer_q];
  assign rd_net_words = net_words_mem[rd_layer_q];

endmodule

// File: rtl/layer_sched.sv
// rtl/layer_sched.sv - layer-by-layer network run scheduler
// Purpose: walks num_layers descriptors, presents each layer's parameters and
//          ping-pong image / weight offsets, and handshakes each layer with the
//          core controller (req pulse, ack low, ack high).
// Ports:   clk, xrst (sync active-high); start/num_layers/in_base/buf_a/buf_b/
//          net_base run setup; cfg_* descriptor writes; core_req/core_ack core
//          handshake; total_out..net_addr current layer outputs; busy, done,
//          layer_idx, result_addr, cfg_err status.
module layer_sched
  import renkon_pkg::*;
#(
  parameter int LWIDTH   = 16,
  parameter int IMGSIZE  = 12,
  parameter int NETSIZE  = 14,
  parameter int MAXLAYER = 16,
  parameter int LAYERLOG = 4
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                start,
  input  logic [LAYERLOG:0]   num_layers,
  input  logic [IMGSIZE-1:0]  in_base,
  input  logic [IMGSIZE-1:0]  buf_a,
  input  logic [IMGSIZE-1:0]  buf_b,
  input  logic [NETSIZE-1:0]  net_base,
  input  logic                cfg_we,
  input  logic [LAYERLOG-1:0] cfg_layer,
  input  logic [2:0]          cfg_sel,
  input  logic [LWIDTH-1:0]   cfg_data,
  output logic                core_req,
  input  logic                core_ack,
  output logic [LWIDTH-1:0]   total_out,
  output logic [LWIDTH-1:0]   total_in,
  output logic [LWIDTH-1:0]   img_size,
  output logic [LWIDTH-1:0]   fil_size,
  output logic [IMGSIZE-1:0]  input_addr,
  output logic [IMGSIZE-1:0]  output_addr,
  output logic [NETSIZE-1:0]  net_addr,
  output logic                busy,
  output logic                done,
  output logic [LAYERLOG-1:0] layer_idx,
  output logic [IMGSIZE-1:0]  result_addr,
  output logic                cfg_err
);

  localparam logic [LAYERLOG:0] MAX_LAYERS = (LAYERLOG+1)'(MAXLAYER);

  state_e              state_q, state_d;
  logic [LAYERLOG-1:0] layer_idx_q, layer_idx_d;
  logic [LAYERLOG:0]   run_len_q, run_len_d;
  logic [NETSIZE-1:0]  acc_q, acc_d;
  logic [NETSIZE-1:0]  net_words_q, net_words_d;
  logic [LWIDTH-1:0]   total_out_q, total_out_d, total_in_q, total_in_d;
  logic [LWIDTH-1:0]   img_size_q, img_size_d, fil_size_q, fil_size_d;
  logic [IMGSIZE-1:0]  input_addr_q, input_addr_d, output_addr_q, output_addr_d;
  logic [IMGSIZE-1:0]  result_addr_q, result_addr_d;
  logic [NETSIZE-1:0]  net_addr_q, net_addr_d;
  logic                core_req_q, core_req_d, busy_q, busy_d;
  logic                done_q, done_d, cfg_err_q, cfg_err_d;

  logic                tbl_we;
  logic [LWIDTH-1:0]   tbl_total_out, tbl_total_in, tbl_img_size, tbl_fil_size;
  logic [NETSIZE-1:0]  tbl_net_words;
  logic                is_last;

  assign tbl_we  = cfg_we && (state_q == S_IDLE);
  assign is_last = ({1'b0, layer_idx_q} == (run_len_q - (LAYERLOG+1)'(1)));

  // Read address follows the next layer index so the entry is ready in S_LOAD.
  layer_table #(
    .LWIDTH(LWIDTH), .NETSIZE(NETSIZE), .MAXLAYER(MAXLAYER), .LAYERLOG(LAYERLOG)
  ) u_table (
    .clk         (clk),
    .wr_en       (tbl_we),
    .wr_layer    (cfg_layer),
    .wr_sel      (cfg_sel),
    .wr_data     (cfg_data),
    .rd_layer    (layer_idx_d),
    .rd_total_out(tbl_total_out),
    .rd_total_in (tbl_total_in),
    .rd_img_size (tbl_img_size),
    .rd_fil_size (tbl_fil_size),
    .rd_net_words(tbl_net_words)
  );

  always_comb begin
    state_d       = state_q;
    layer_idx_d   = layer_idx_q;
    run_len_d     = run_len_q;
    acc_d         = acc_q;
    net_words_d   = net_words_q;
    total_out_d   = total_out_q;
    total_in_d    = total_in_q;
    img_size_d    = img_size_q;
    fil_size_d    = fil_size_q;
    input_addr_d  = input_addr_q;
    output_addr_d = output_addr_q;
    net_addr_d    = net_addr_q;
    result_addr_d = result_addr_q;
    core_req_d    = 1'b0;
    done_d        = 1'b0;
    cfg_err_d     = cfg_err_q;

    if (cfg_we && state_q != S_IDLE && cfg_sel_valid(cfg_sel)) begin
      cfg_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_err_d = 1'b0;
          if (num_layers == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_LOAD;
            layer_idx_d = '0;
            acc_d       = '0;
            run_len_d   = (num_layers > MAX_LAYERS) ? MAX_LAYERS : num_layers;
          end
        end
      end
      S_LOAD: begin
        total_out_d   = tbl_total_out;
        total_in_d    = tbl_total_in;
        img_size_d    = tbl_img_size;
        fil_size_d    = tbl_fil_size;
        net_words_d   = tbl_net_words;
        input_addr_d  = (layer_idx_q == '0) ? in_base : output_addr_q;
        output_addr_d = layer_idx_q[0] ? buf_b : buf_a;
        net_addr_d    = net_base + acc_q;
        core_req_d    = 1'b1;
        state_d       = S_REQ;
      end
      S_REQ:    state_d = S_ACK_LO;
      S_ACK_LO: if (!core_ack) state_d = S_RUN;
      S_RUN:    if (core_ack) state_d = S_NEXT;
      S_NEXT: begin
        acc_d = acc_q + net_words_q;
        if (is_last) begin
          state_d       = S_IDLE;
          done_d        = 1'b1;
          result_addr_d = output_addr_q;
        end else begin
          layer_idx_d = layer_idx_q + LAYERLOG'(1);
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q       <= S_IDLE;
      layer_idx_q   <= '0;
      run_len_q     <= '0;
      acc_q         <= '0;
      net_words_q   <= '0;
      total_out_q   <= '0;
      total_in_q    <= '0;
      img_size_q    <= '0;
      fil_size_q    <= '0;
      input_addr_q  <= '0;
      output_addr_q <= '0;
      net_addr_q    <= '0;
      result_addr_q <= '0;
      core_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_idx_q   <= layer_idx_d;
      run_len_q     <= run_len_d;
      acc_q         <= acc_d;
      net_words_q   <= net_words_d;
      total_out_q   <= total_out_d;
      total_in_q    <= total_in_d;
      img_size_q    <= img_size_d;
      fil_size_q    <= fil_size_d;
      input_addr_q  <= input_addr_d;
      output_addr_q <= output_addr_d;
      net_addr_q    <= net_addr_d;
      result_addr_q <= result_addr_d;
      core_req_q    <= core_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign core_req    = core_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign layer_idx   = layer_idx_q;
  assign total_out   = total_out_q;
  assign total_in    = total_in_q;
  assign img_size    = img_size_q;
  assign fil_size    = fil_size_q;
  assign input_addr  = input_addr_q;
  assign output_addr = output_addr_q;
  assign net_addr    = net_addr_q;
  assign result_addr = result_addr_q;

endmodule

// File: tb/tb_layer_sched.sv
// tb/tb_layer_sched.sv - scoreboard bench for layer_sched
module tb_layer_sched;
  localparam int LW = 16, IS = 12, NS = 14, ML = 16, LL = 4;

  logic          clk = 1'b0, xrst = 1'b1, start = 1'b0;
  logic [LL:0]   num_layers = '0;
  logic [IS-1:0] in_base = '0, buf_a = '0, buf_b = '0;
  logic [NS-1:0] net_base = '0;
  logic          cfg_we = 1'b0;
  logic [LL-1:0] cfg_layer = '0;
  logic [2:0]    cfg_sel = '0;
  logic [LW-1:0] cfg_data = '0;
  logic          core_req, core_ack = 1'b1;
  logic [LW-1:0] total_out, total_in, img_size, fil_size;
  logic [IS-1:0] input_addr, output_addr, result_addr;
  logic [NS-1:0] net_addr;
  logic          busy, done, cfg_err;
  logic [LL-1:0] layer_idx;

  layer_sched #(.LWIDTH(LW), .IMGSIZE(IS), .NETSIZE(NS), .MAXLAYER(ML), .LAYERLOG(LL)) dut (
    .clk(clk), .xrst(xrst), .start(start), .num_layers(num_layers), .in_base(in_base),
    .buf_a(buf_a), .buf_b(buf_b), .net_base(net_base), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .core_req(core_req), .core_ack(core_ack),
    .total_out(total_out), .total_in(total_in), .img_size(img_size), .fil_size(fil_size),
    .input_addr(input_addr), .output_addr(output_addr), .net_addr(net_addr), .busy(busy),
    .done(done), .layer_idx(layer_idx), .result_addr(result_addr), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int to; int ti; int is; int fs; int ia; int oa; int na; } lay_t;
  typedef struct { int res; bit zero; } dn_t;

  lay_t exp_l[$];
  dn_t  exp_d[$];
  int   m_to[ML], m_ti[ML], m_is[ML], m_fs[ML], m_nw[ML];
  int   total = 0, bad = 0;
  int   start_cyc = 0, ack_rise_cyc = 0, model_res = 0, req_cnt = 0, exp_req_total = 0;
  bit   first_pending = 0, exp_err = 0, req_seen = 0, hold_en = 0;
  int   hold_layer = 0, rsp_st = 0, rsp_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT requests a layer or finishes.
  always @(negedge clk) begin
    lay_t e;
    dn_t  d;
    if (!xrst) begin
      if (core_req) begin
        req_seen = 1;
        req_cnt++;
        chk("req_busy", int'(busy), 1);
        if (first_pending) begin
          chk("req_latency", cyc - start_cyc, 2);
          first_pending = 0;
        end
        chk("req_expected", int'(exp_l.size() != 0), 1);
        if (exp_l.size() != 0) begin
          e = exp_l.pop_front();
          chk("total_out", int'(total_out), e.to);
          chk("total_in", int'(total_in), e.ti);
          chk("img_size", int'(img_size), e.is);
          chk("fil_size", int'(fil_size), e.fs);
          chk("input_addr", int'(input_addr), e.ia);
          chk("output_addr", int'(output_addr), e.oa);
          chk("net_addr", int'(net_addr), e.na);
        end
      end
      if (done) begin
        chk("done_expected", int'(exp_d.size() != 0), 1);
        if (exp_d.size() != 0) begin
          d = exp_d.pop_front();
          chk("result_addr", int'(result_addr), d.res);
          if (d.zero) chk("done_latency_zero", cyc - start_cyc, 1);
          else        chk("done_latency", cyc - ack_rise_cyc, 2);
          chk("done_busy", int'(busy), 0);
        end
      end
    end
  end

  // Core controller model: ack low some cycles after req, high again later.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (xrst) begin
        rsp_st = 0; core_ack = 1'b1; req_seen = 0;
      end else begin
        case (rsp_st)
          0: if (req_seen) begin req_seen = 0; rsp_cnt = $urandom_range(0, 2); rsp_st = 1; end
          1: if (rsp_cnt == 0) begin core_ack = 1'b0; rsp_cnt = $urandom_range(1, 3); rsp_st = 2; end
             else rsp_cnt--;
          default: if (!(hold_en && int'(layer_idx) == hold_layer)) begin
            if (rsp_cnt <= 1) begin core_ack = 1'b1; ack_rise_cyc = cyc; rsp_st = 0; end
            else rsp_cnt--;
          end
        endcase
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic void model_set(input int l, input int s, input int v);
    case (s)
      0: m_to[l] = v;
      1: m_ti[l] = v;
      2: m_is[l] = v;
      3: m_fs[l] = v;
      4: m_nw[l] = v % (1 << NS);
      default: ;
    endcase
  endfunction

  task automatic wr(input int l, input int s, input int v, input bit idle);
    cfg_we = 1'b1; cfg_layer = l[LL-1:0]; cfg_sel = s[2:0]; cfg_data = v[LW-1:0];
    if (idle) model_set(l, s, v);
    tick;
    cfg_we = 1'b0;
  endtask

  // Starts a run; optional descriptor write in the same cycle lands first.
  task automatic run(input int nl, input int ib, input int a, input int b, input int nb,
                     input bit w, input int wl, input int ws, input int wv);
    int n, acc, prev;
    lay_t e;
    dn_t d;
    num_layers = nl[LL:0]; in_base = ib[IS-1:0]; buf_a = a[IS-1:0]; buf_b = b[IS-1:0];
    net_base = nb[NS-1:0];
    if (w) begin
      cfg_we = 1'b1; cfg_layer = wl[LL-1:0]; cfg_sel = ws[2:0]; cfg_data = wv[LW-1:0];
      model_set(wl, ws, wv);
    end
    n = (nl > ML) ? ML : nl;
    exp_err = 0;
    if (n == 0) begin
      d.res = model_res; d.zero = 1; exp_d.push_back(d);
    end else begin
      acc = 0; prev = ib;
      for (int i = 0; i < n; i++) begin
        e.to = m_to[i]; e.ti = m_ti[i]; e.is = m_is[i]; e.fs = m_fs[i];
        e.oa = (i % 2 == 1) ? b : a;
        e.ia = (i == 0) ? ib : prev;
        e.na = (nb + acc) % (1 << NS);
        exp_l.push_back(e);
        acc += m_nw[i];
        prev = e.oa;
      end
      model_res = prev; d.res = prev; d.zero = 0; exp_d.push_back(d);
      exp_req_total += n;
    end
    start = 1'b1;
    start_cyc = cyc;
    first_pending = (n > 0);
    tick;
    start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_l.size() != 0 || exp_d.size() != 0) && k < budget) begin tick; k++; end
    chk("run_timeout", int'(exp_l.size() + exp_d.size()), 0);
    tick;
    chk("idle_busy", int'(busy), 0);
    chk("cfg_err", int'(cfg_err), int'(exp_err));
  endtask

  task automatic wait_run_layer(input int l);
    int k = 0;
    while (!(int'(layer_idx) == l && core_ack == 1'b0 && busy) && k < 500) begin tick; k++; end
    chk("reach_run", int'(k < 500), 1);
    tick;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_core_req"}, int'(core_req), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_layer_idx"}, int'(layer_idx), 0);
    chk({tag, "_total_out"}, int'(total_out), 0);
    chk({tag, "_total_in"}, int'(total_in), 0);
    chk({tag, "_img_size"}, int'(img_size), 0);
    chk({tag, "_fil_size"}, int'(fil_size), 0);
    chk({tag, "_input_addr"}, int'(input_addr), 0);
    chk({tag, "_output_addr"}, int'(output_addr), 0);
    chk({tag, "_net_addr"}, int'(net_addr), 0);
    chk({tag, "_result_addr"}, int'(result_addr), 0);
  endtask

  initial begin
    int r0;
    repeat (3) tick;
    xrst = 1'b0;
    chk_all_zero("rst");

    for (int l = 0; l < ML; l++)
      for (int s = 0; s < 5; s++) wr(l, s, int'($urandom_range(0, 16'hFFFF)), 1);

    // Single layer
    wr(0, 0, 32, 1); wr(0, 1, 3, 1); wr(0, 2, 12, 1); wr(0, 3, 5, 1); wr(0, 4, 400, 1);
    run(1, 'h000, 'h400, 'h800, 'h10, 0, 0, 0, 0);
    wait_idle(500);

    // Three layers, ping-pong buffers and accumulated weight offsets
    wr(1, 4, 200, 1); wr(2, 4, 100, 1);
    run(3, 'h000, 'h400, 'h800, 'h10, 0, 0, 0, 0);
    wait_idle(1000);

    // Zero layers: immediate done, never busy
    run(0, 'h123, 'h400, 'h800, 'h10, 0, 0, 0, 0);
    chk("zero_busy", int'(busy), 0);
    tick;
    chk("zero_busy_later", int'(busy), 0);
    wait_idle(100);

    // Writes while busy: out-of-range select ignored, valid select flagged and dropped
    hold_en = 1; hold_layer = 0;
    run(2, 'h020, 'h300, 'h700, 'h3FF0, 0, 0, 0, 0);
    wait_run_layer(0);
    wr(1, 6, 'h55, 0);
    chk("cfg_err_sel_hi", int'(cfg_err), 0);
    wr(1, 0, 999, 0);
    chk("cfg_err_set", int'(cfg_err), 1);
    exp_err = 1;
    hold_en = 0;
    wait_idle(1000);

    // start during S_ACK_LO must be ignored
    r0 = req_cnt;
    run(2, 'h040, 'h500, 'h600, 'h100, 0, 0, 0, 0);
    begin
      int k = 0;
      while (!core_req && k < 100) begin @(negedge clk); k++; end
      tick;
      num_layers = 5'd3; start = 1'b1;
      tick;
      start = 1'b0;
    end
    wait_idle(1000);
    chk("ack_lo_req_count", req_cnt - r0, 2);

    // Reset during S_RUN of layer 1
    hold_en = 1; hold_layer = 1;
    run(2, 'h000, 'h400, 'h800, 'h10, 0, 0, 0, 0);
    wait_run_layer(1);
    xrst = 1'b1;
    tick;
    xrst = 1'b0;
    chk_all_zero("midrst");
    chk("midrst_layers_issued", int'(exp_l.size()), 0);
    exp_d.delete();
    model_res = 0;
    hold_en = 0;
    repeat (3) tick;
    run(1, 'h010, 'h200, 'h300, 'h20, 0, 0, 0, 0);
    wait_idle(500);

    // Randomized runs, including same-cycle write+start and num_layers saturation
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 4))
        wr($urandom_range(0, ML-1), $urandom_range(0, 7), int'($urandom_range(0, 16'hFFFF)), 1);
      run($urandom_range(0, 20), $urandom_range(0, 4095), $urandom_range(0, 4095),
          $urandom_range(0, 4095), $urandom_range(0, 16383), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3), $urandom_range(0, 4), int'($urandom_range(0, 16'hFFFF)));
      wait_idle(3000);
    end

    chk("req_count", req_cnt, exp_req_total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
